// File: rtl/data_mem_param.sv
// Parametrised single-port data memory: byte-enable writes, two-stage registered
// response, address checking, saturating error counter and a clear-on-reset sequencer.

module data_mem_lane (
  input  logic       be,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = be ? new_byte : old_byte;
endmodule

module data_mem_param #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 32,
  parameter int                WR_FIRST  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [7:0]          err_count
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF       = $clog2(NUM_LANES);
  localparam int IDX       = $clog2(DEPTH);

  typedef logic [NUM_LANES-1:0][7:0] word_t;
  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX-1:0]   clr_cnt;
  logic             clr_we;

  logic [IDX-1:0]   idx;
  logic             mis, oor, acc, acc_err, acc_we;
  word_t            mem [DEPTH];
  word_t            rd_word, wdata_b, merged;

  logic [1:0]       vld_pipe;
  logic             s1_err;
  word_t            s1_data;

  // ---------------- clear sequencer / request gating ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_cnt == IDX'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN:     req_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  // ---------------- address decode ----------------
  assign idx = req_addr[OFF+IDX-1:OFF];

  if (OFF > 0) begin : g_mis
    assign mis = |req_addr[OFF-1:0];
  end else begin : g_nomis
    assign mis = 1'b0;
  end

  if (ADDR_W > OFF + IDX) begin : g_oor
    assign oor = |req_addr[ADDR_W-1:OFF+IDX];
  end else begin : g_nooor
    assign oor = 1'b0;
  end

  assign acc     = req_valid && req_ready;
  assign acc_err = mis || oor;
  assign acc_we  = acc && req_write && !acc_err;

  // ---------------- storage and byte merge ----------------
  assign rd_word = mem[idx];
  assign wdata_b = req_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_mem_lane u_lane (
      .be       (req_be[i]),
      .old_byte (rd_word[i]),
      .new_byte (wdata_b[i]),
      .merged   (merged[i])
    );
  end

  // Memory is not reset; the clear sequence runs once reset drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we)      mem[clr_cnt] <= CLEAR_VAL;
      else if (acc_we) mem[idx]     <= merged;
    end
  end

  // ---------------- response pipeline ----------------
  // Memory is updated on the accept edge, so a following read already sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_err    <= 1'b0;
      s1_data   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], acc};
      if (acc) begin
        s1_err <= acc_err;
        if (acc_err)                         s1_data <= '0;
        else if (req_write && WR_FIRST != 0) s1_data <= merged;
        else                                 s1_data <= rd_word;
      end
      rsp_rdata <= vld_pipe[0] ? DATA_W'(s1_data) : '0;
      rsp_err   <= vld_pipe[0] && s1_err;
      if (vld_pipe[0] && s1_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign rsp_valid = vld_pipe[1];

endmodule
